// File: rtl/sample_counter_pkg.sv
// Shared correlator definitions: sample-counter FSM encoding and the default
// count width / synchronizer depth reused by the correlator channels.
package sample_counter_pkg;

    localparam int DEF_CNT_W       = 8;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/sample_counter_if.sv
// Valid/ready sample stream from the sample counter toward the channel logic.
interface sample_counter_if
    import sample_counter_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);

    logic [CNT_W-1:0] sample_data;
    logic             sample_sat;
    logic             sample_valid;
    logic             sample_ready;

    modport master (
        output sample_data,
        output sample_sat,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_sat,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/sample_counter_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level, followed by a history
// flop so the rising edge can be reported as a one-cycle pulse.
module sync_edge_det
    import sample_counter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk_in_0,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hist_r;

    // Shift the raw input through the synchronizer chain and keep one cycle of history.
    always_ff @(posedge clk_in_0 or posedge rst) begin
        if (rst) begin
            sync_r <= '0;
            hist_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
            hist_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign sync_out = sync_r[SYNC_STAGES-1];
    assign rise     = sync_r[SYNC_STAGES-1] & ~hist_r;

endmodule

// File: rtl/sample_counter.sv
// Photon-pulse counter: counts pulse_in edges over each interval delimited by
// rising edges of the divided sample clock (treated as data) and emits one
// count word per interval through a one-entry valid/ready output register.
module sample_counter
    import sample_counter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                    clk_in_0,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    sample_clk,
    input  logic                    pulse_in,
    input  logic                    clr_ovr,
    output logic                    overrun,
    sample_counter_if.master        sample_if
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             tick_s;
    logic             pulse_evt_s;
    logic             sclk_lvl_unused_s;
    logic             pulse_lvl_unused_s;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] acc_r;
    logic [CNT_W-1:0] acc_nxt_s;
    logic             sat_acc_r;
    logic             sat_acc_nxt_s;
    logic             emit_s;
    logic             load_s;
    logic             drop_s;

    logic [CNT_W-1:0] data_r;
    logic             sat_r;
    logic             valid_r;
    logic             overrun_r;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk_in_0 (clk_in_0),
        .rst      (rst),
        .async_in (sample_clk),
        .sync_out (sclk_lvl_unused_s),
        .rise     (tick_s)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_pulse (
        .clk_in_0 (clk_in_0),
        .rst      (rst),
        .async_in (pulse_in),
        .sync_out (pulse_lvl_unused_s),
        .rise     (pulse_evt_s)
    );

    // Next-state and accumulator update; a pulse coincident with a tick opens the new interval.
    always_comb begin
        state_nxt_s   = state_r;
        acc_nxt_s     = acc_r;
        sat_acc_nxt_s = sat_acc_r;
        emit_s        = 1'b0;
        if (!en) begin
            state_nxt_s   = ST_IDLE;
            acc_nxt_s     = '0;
            sat_acc_nxt_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    acc_nxt_s     = '0;
                    sat_acc_nxt_s = 1'b0;
                    state_nxt_s   = ST_ARM;
                end
                ST_ARM: begin
                    sat_acc_nxt_s = 1'b0;
                    if (tick_s) begin
                        acc_nxt_s   = pulse_evt_s ? CNT_ONE : '0;
                        state_nxt_s = ST_RUN;
                    end else begin
                        acc_nxt_s   = '0;
                        state_nxt_s = ST_ARM;
                    end
                end
                ST_RUN: begin
                    if (tick_s) begin
                        emit_s        = 1'b1;
                        acc_nxt_s     = pulse_evt_s ? CNT_ONE : '0;
                        sat_acc_nxt_s = 1'b0;
                    end else if (pulse_evt_s) begin
                        if (acc_r == CNT_MAX) begin
                            sat_acc_nxt_s = 1'b1;
                        end else begin
                            acc_nxt_s = acc_r + CNT_ONE;
                        end
                    end else begin
                        acc_nxt_s = acc_r;
                    end
                end
                default: begin
                    state_nxt_s   = ST_IDLE;
                    acc_nxt_s     = '0;
                    sat_acc_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // FSM state, accumulator and saturation flag registers.
    always_ff @(posedge clk_in_0 or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            acc_r     <= '0;
            sat_acc_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            acc_r     <= acc_nxt_s;
            sat_acc_r <= sat_acc_nxt_s;
        end
    end

    // The output slot is free when empty or being drained this very cycle.
    assign load_s = emit_s & (~valid_r | sample_if.sample_ready);
    assign drop_s = emit_s & valid_r & ~sample_if.sample_ready;

    // One-entry output register with sticky overrun; a new drop beats clr_ovr.
    always_ff @(posedge clk_in_0 or posedge rst) begin
        if (rst) begin
            data_r    <= '0;
            sat_r     <= 1'b0;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (load_s) begin
                data_r  <= acc_r;
                sat_r   <= sat_acc_r;
                valid_r <= 1'b1;
            end else if (valid_r && sample_if.sample_ready) begin
                valid_r <= 1'b0;
            end
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else if (clr_ovr) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign sample_if.sample_data  = data_r;
    assign sample_if.sample_sat   = sat_r;
    assign sample_if.sample_valid = valid_r;
    assign overrun                = overrun_r;

endmodule

// File: tb/tb_sample_counter.sv
// Bench for sample_counter: table-driven intervals feeding a scoreboard that a
// negedge monitor drains on every valid&ready transfer, plus hand sequences
// for backpressure/overrun, drain-plus-load, async reset and enable toggling.
module tb_sample_counter;

    typedef struct {
        logic [7:0] data;
        logic       sat;
    } samp_t;

    typedef struct {
        int         n;
        int         gap;
        int         len;
        bit         coinc;
        logic [7:0] ed;
        bit         es;
    } vec_t;

    typedef enum int {M_NORM, M_LAT, M_DROP, M_DRAIN} mode_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic sclk = 1'b0;
    logic pulse = 1'b0;
    logic clr_ovr = 1'b0;
    logic ready = 1'b1;
    logic overrun;

    int n_cmp = 0;
    int n_bad = 0;

    samp_t sb[$];
    bit         pend_valid = 1'b0;
    logic [7:0] pend_d = 8'd0;
    bit         pend_s = 1'b0;

    vec_t tbl[8];

    sample_counter_if #(.CNT_W(8)) sif ();
    assign sif.sample_ready = ready;

    sample_counter #(.CNT_W(8), .SYNC_STAGES(2)) dut (
        .clk_in_0   (clk),
        .rst        (rst),
        .en         (en),
        .sample_clk (sclk),
        .pulse_in   (pulse),
        .clr_ovr    (clr_ovr),
        .overrun    (overrun),
        .sample_if  (sif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Every accepted transfer must match the oldest expected sample.
    always @(negedge clk) begin
        if (!rst && sif.sample_valid && sif.sample_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_xfer: got data=%0d sat=%0d, expected no transfer",
                         sif.sample_data, sif.sample_sat);
            end else begin
                samp_t e;
                e = sb.pop_front();
                chk("xfer_data", int'(sif.sample_data), int'(e.data));
                chk("xfer_sat", int'(sif.sample_sat), int'(e.sat));
            end
        end
    end

    function automatic bit pulse_at(input int c, input int n, input int gap);
        int rel;
        if (c < 4) return 1'b0;
        rel = c - 4;
        return ((rel / gap) < n) && ((rel % gap) < 2);
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            sclk  = 1'b0;
            pulse = 1'b0;
        end
    endtask

    // One sample interval starting with a sample_clk rise; the previous interval's
    // expected sample is pushed at its tick unless that tick is expected to drop it.
    task automatic interval(input int n, input int gap, input int len, input bit coinc,
                            input logic [7:0] ed, input bit es, input mode_t mode);
        logic [7:0] pd;
        bit         did_push;
        pd       = 8'd0;
        did_push = 1'b0;
        if (pend_valid && mode != M_DROP) begin
            sb.push_back('{pend_d, pend_s});
            pd       = pend_d;
            did_push = 1'b1;
        end
        for (int c = 0; c < len; c++) begin
            @(posedge clk);
            #1;
            if (mode == M_LAT && did_push && c == 2) chk("lat_pre", int'(sif.sample_valid), 0);
            if (mode == M_LAT && did_push && c == 3) chk("lat_valid", int'(sif.sample_valid), 1);
            if (mode == M_DRAIN && c == 2) begin
                chk("drain_hold_valid", int'(sif.sample_valid), 1);
                if (sb.size() > 0) chk("drain_hold_data", int'(sif.sample_data), int'(sb[0].data));
                ready = 1'b1;
            end
            if (mode == M_DRAIN && c == 3) begin
                chk("drain_new_valid", int'(sif.sample_valid), 1);
                chk("drain_new_data", int'(sif.sample_data), int'(pd));
            end
            sclk  = (c < len / 2);
            pulse = (coinc && c < 2) || pulse_at(c, n, gap);
        end
        pend_valid = 1'b1;
        pend_d     = ed;
        pend_s     = es;
    endtask

    initial begin
        tbl[0] = '{n: 5,   gap: 10, len: 64,   coinc: 1'b0, ed: 8'd5,   es: 1'b0};
        tbl[1] = '{n: 5,   gap: 10, len: 64,   coinc: 1'b0, ed: 8'd5,   es: 1'b0};
        tbl[2] = '{n: 5,   gap: 10, len: 64,   coinc: 1'b0, ed: 8'd5,   es: 1'b0};
        tbl[3] = '{n: 300, gap: 4,  len: 1400, coinc: 1'b0, ed: 8'd255, es: 1'b1};
        tbl[4] = '{n: 3,   gap: 10, len: 64,   coinc: 1'b0, ed: 8'd3,   es: 1'b0};
        tbl[5] = '{n: 4,   gap: 10, len: 64,   coinc: 1'b0, ed: 8'd4,   es: 1'b0};
        tbl[6] = '{n: 2,   gap: 10, len: 64,   coinc: 1'b1, ed: 8'd3,   es: 1'b0};
        tbl[7] = '{n: 1,   gap: 10, len: 64,   coinc: 1'b0, ed: 8'd1,   es: 1'b0};

        // Reset state
        idle(3);
        chk("rst_valid", int'(sif.sample_valid), 0);
        chk("rst_data", int'(sif.sample_data), 0);
        chk("rst_sat", int'(sif.sample_sat), 0);
        chk("rst_overrun", int'(overrun), 0);
        rst = 1'b0;
        en  = 1'b1;
        idle(4);

        // Table: basic counts, saturation and recovery, coincidence
        for (int i = 0; i < 8; i++) begin
            interval(tbl[i].n, tbl[i].gap, tbl[i].len, tbl[i].coinc, tbl[i].ed, tbl[i].es, M_LAT);
        end

        // Backpressure across two ticks: 7 is held, 9 is dropped
        interval(7, 6, 64, 1'b0, 8'd7, 1'b0, M_NORM);
        ready = 1'b0;
        interval(9, 6, 64, 1'b0, 8'd9, 1'b0, M_NORM);
        interval(6, 6, 64, 1'b0, 8'd6, 1'b0, M_DROP);
        chk("bp_valid", int'(sif.sample_valid), 1);
        chk("bp_hold_data", int'(sif.sample_data), 7);
        chk("bp_overrun", int'(overrun), 1);
        ready = 1'b1;
        idle(4);
        chk("ovr_sticky", int'(overrun), 1);
        clr_ovr = 1'b1;
        idle(1);
        clr_ovr = 1'b0;
        chk("ovr_cleared", int'(overrun), 0);

        // Drain plus load in the same cycle
        ready = 1'b0;
        interval(2, 6, 64, 1'b0, 8'd2, 1'b0, M_NORM);
        interval(3, 6, 64, 1'b0, 8'd3, 1'b0, M_DRAIN);

        // Asynchronous reset with a sample held
        ready = 1'b0;
        interval(4, 6, 64, 1'b0, 8'd4, 1'b0, M_NORM);
        chk("pre_rst_valid", int'(sif.sample_valid), 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        sb.delete();
        pend_valid = 1'b0;
        #1;
        chk("arst_valid", int'(sif.sample_valid), 0);
        chk("arst_data", int'(sif.sample_data), 0);
        chk("arst_sat", int'(sif.sample_sat), 0);
        chk("arst_overrun", int'(overrun), 0);
        idle(2);
        rst   = 1'b0;
        ready = 1'b1;
        idle(4);

        // Enable toggle discards the partial interval; first tick after re-enable is silent
        interval(2, 6, 64, 1'b0, 8'd2, 1'b0, M_NORM);
        interval(4, 6, 64, 1'b0, 8'd4, 1'b0, M_NORM);
        en = 1'b0;
        idle(4);
        en = 1'b1;
        idle(4);
        pend_valid = 1'b0;
        interval(5, 6, 64, 1'b0, 8'd5, 1'b0, M_NORM);
        interval(0, 6, 64, 1'b0, 8'd0, 1'b0, M_LAT);
        idle(10);
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
